// File: rtl/loop_gear_ctrl_pkg.sv
// Shared definitions for the loop gear sequencer and its helpers.
// State encodings double as the status-register value of the state port.
package loop_gear_ctrl_pkg;

    localparam int EXP_W = 5;
    localparam int ERR_W = 8;
    localparam int CNT_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_TRACK  = 2'd3;

    // Saturating increment for the full-width sample counters.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/loop_err_mag.sv
// Loop error magnitude and threshold qualifier.
// |error| with the most negative code clamped to the most positive one, so the
// magnitude always fits the signed range; inTh is an unsigned <= compare.
module loop_err_mag
    import loop_gear_ctrl_pkg::*;
(
    input  logic [ERR_W-1:0] error,
    input  logic [ERR_W-1:0] threshold,
    output logic             in_th
);

    logic [ERR_W-1:0] mag;

    // Absolute value with -128 -> 127 clamp, then threshold compare.
    always_comb begin
        if (!error[ERR_W-1]) begin
            mag = error;
        end else if (error == {1'b1, {(ERR_W-1){1'b0}}}) begin
            mag = {1'b0, {(ERR_W-1){1'b1}}};
        end else begin
            mag = ~error + 1'b1;
        end
        in_th = (mag <= threshold);
    end

endmodule

// File: rtl/loop_gear_ctrl.sv
// Acquisition/tracking gear sequencer for the carrier/symbol loop filter.
// Optional ACQ dwell timeout enabled by defining LOOP_GEAR_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | loop stopped, filter error forced to zero, acquisition gear
// ACQ    | wide gear, waiting for lockCount consecutive in-threshold samples
// VERIFY | narrow gear, requalifying lock with another lockCount samples
// TRACK  | narrow gear, locked; leaves on MISS_LIMIT misses or any saturation
module loop_gear_ctrl
    import loop_gear_ctrl_pkg::*;
#(
    parameter int MISS_LIMIT  = 16,
    parameter int SAT_LIMIT   = 8
`ifdef LOOP_GEAR_TIMEOUT_EN
   ,parameter int ACQ_TIMEOUT = 65535
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clkEn,
    input  logic             enable,
    input  logic [ERR_W-1:0] error,
    input  logic             satPos,
    input  logic             satNeg,
    input  logic [CNT_W-1:0] lockCount,
    input  logic [ERR_W-1:0] syncThreshold,
    input  logic [EXP_W-1:0] acqLead,
    input  logic [EXP_W-1:0] acqLag,
    input  logic [EXP_W-1:0] trkLead,
    input  logic [EXP_W-1:0] trkLag,
    output logic [EXP_W-1:0] leadExp,
    output logic [EXP_W-1:0] lagExp,
    output logic             zeroError,
    output logic             clearAccum,
    output logic             lockDetect,
    output logic [1:0]       state
);

    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int SAT_W  = $clog2(SAT_LIMIT + 1);
    localparam logic [MISS_W-1:0] MISS_LIM_V = MISS_W'(MISS_LIMIT);
    localparam logic [SAT_W-1:0]  SAT_LIM_V  = SAT_W'(SAT_LIMIT);

    logic              in_th;
    logic              sat;
    logic [CNT_W-1:0]  lc_eff;
    logic [1:0]        st_n;
    logic              clr_n;
    logic              trk_gear;
    logic [CNT_W-1:0]  hit_cnt,  hit_n,  hit_step;
    logic [MISS_W-1:0] miss_cnt, miss_n, miss_step;
    logic [SAT_W-1:0]  sat_cnt,  sat_n,  sat_step;

`ifdef LOOP_GEAR_TIMEOUT_EN
    localparam int ACQ_W = $clog2(ACQ_TIMEOUT + 1);
    localparam logic [ACQ_W-1:0] ACQ_LIM_V = ACQ_W'(ACQ_TIMEOUT);
    logic [ACQ_W-1:0] acq_cnt, acq_n, acq_step;
    logic             timeout;
    assign acq_step = (&acq_cnt) ? acq_cnt : acq_cnt + 1'b1;
    assign timeout  = (acq_step >= ACQ_LIM_V);
`endif

    loop_err_mag u_err_mag (
        .error     (error),
        .threshold (syncThreshold),
        .in_th     (in_th)
    );

    assign sat       = satPos | satNeg;
    assign lc_eff    = (lockCount == '0) ? CNT_W'(1) : lockCount;
    assign hit_step  = in_th ? sat_inc_cnt(hit_cnt) : '0;
    assign sat_step  = sat ? ((&sat_cnt) ? sat_cnt : sat_cnt + 1'b1) : '0;
    assign miss_step = in_th ? '0 : ((&miss_cnt) ? miss_cnt : miss_cnt + 1'b1);
    assign trk_gear  = (st_n == ST_VERIFY) || (st_n == ST_TRACK);

    // Next-state and counter decisions; enable=0 beats saturation beats threshold.
    always_comb begin
        st_n   = state;
        hit_n  = hit_cnt;
        miss_n = miss_cnt;
        sat_n  = sat_cnt;
        clr_n  = 1'b0;
`ifdef LOOP_GEAR_TIMEOUT_EN
        acq_n  = acq_cnt;
`endif
        if (!enable) begin
            st_n   = ST_IDLE;
            hit_n  = '0;
            miss_n = '0;
            sat_n  = '0;
`ifdef LOOP_GEAR_TIMEOUT_EN
            acq_n  = '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    st_n  = ST_ACQ;
                    clr_n = 1'b1;
                end
                ST_ACQ: if (clkEn) begin
                    if (sat_step >= SAT_LIM_V) begin
                        clr_n = 1'b1;
                        sat_n = '0;
                        hit_n = '0;
`ifdef LOOP_GEAR_TIMEOUT_EN
                        acq_n = timeout ? '0 : acq_step;
`endif
                    end else if (hit_step >= lc_eff) begin
                        st_n  = ST_VERIFY;
                        hit_n = '0;
                        sat_n = '0;
`ifdef LOOP_GEAR_TIMEOUT_EN
                        acq_n = '0;
`endif
                    end
`ifdef LOOP_GEAR_TIMEOUT_EN
                    else if (timeout) begin
                        clr_n = 1'b1;
                        hit_n = '0;
                        sat_n = sat_step;
                        acq_n = '0;
                    end
`endif
                    else begin
                        hit_n = hit_step;
                        sat_n = sat_step;
`ifdef LOOP_GEAR_TIMEOUT_EN
                        acq_n = acq_step;
`endif
                    end
                end
                ST_VERIFY: if (clkEn) begin
                    if (sat || !in_th) begin
                        st_n  = ST_ACQ;
                        hit_n = '0;
                    end else if (hit_step >= lc_eff) begin
                        st_n  = ST_TRACK;
                        hit_n = '0;
                    end else begin
                        hit_n = hit_step;
                    end
                end
                default: if (clkEn) begin
                    if (sat || (miss_step >= MISS_LIM_V)) begin
                        st_n   = ST_ACQ;
                        miss_n = '0;
                    end else begin
                        miss_n = miss_step;
                    end
                end
            endcase
        end
    end

    // Register state, counters and outputs; gear follows the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            sat_cnt    <= '0;
            leadExp    <= acqLead;
            lagExp     <= acqLag;
            zeroError  <= 1'b1;
            clearAccum <= 1'b0;
            lockDetect <= 1'b0;
`ifdef LOOP_GEAR_TIMEOUT_EN
            acq_cnt    <= '0;
`endif
        end else begin
            state      <= st_n;
            hit_cnt    <= hit_n;
            miss_cnt   <= miss_n;
            sat_cnt    <= sat_n;
            leadExp    <= trk_gear ? trkLead : acqLead;
            lagExp     <= trk_gear ? trkLag : acqLag;
            zeroError  <= (st_n == ST_IDLE);
            clearAccum <= clr_n;
            lockDetect <= (st_n == ST_TRACK);
`ifdef LOOP_GEAR_TIMEOUT_EN
            acq_cnt    <= acq_n;
`endif
        end
    end

endmodule

// File: tb/tb_loop_gear_ctrl.sv
// Testbench for loop_gear_ctrl: table vectors, directed corner sequences and
// randomized traffic against a sample-level behavioural model.
module tb_loop_gear_ctrl;

    localparam int MISS_LIMIT  = 16;
    localparam int SAT_LIMIT   = 8;
    localparam int ACQ_TIMEOUT = 20;
    localparam int M_IDLE = 0, M_ACQ = 1, M_VERIFY = 2, M_TRACK = 3;

    logic        clk;
    logic        rst, en, clk_en, sat_pos, sat_neg;
    logic [7:0]  err, sync_th;
    logic [15:0] lock_count;
    logic [4:0]  acq_lead, acq_lag, trk_lead, trk_lag;
    logic [4:0]  lead_exp, lag_exp;
    logic        zero_err, clr_acc, lock_det;
    logic [1:0]  st;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    int m_mode, m_hit, m_miss, m_sat, m_acq;
    int m_lead, m_lag;
    bit m_zero, m_clr, m_lock;

`ifdef LOOP_GEAR_TIMEOUT_EN
    loop_gear_ctrl #(.MISS_LIMIT(MISS_LIMIT), .SAT_LIMIT(SAT_LIMIT), .ACQ_TIMEOUT(ACQ_TIMEOUT)) dut (
`else
    loop_gear_ctrl #(.MISS_LIMIT(MISS_LIMIT), .SAT_LIMIT(SAT_LIMIT)) dut (
`endif
        .clk(clk), .reset(rst), .clkEn(clk_en), .enable(en), .error(err),
        .satPos(sat_pos), .satNeg(sat_neg), .lockCount(lock_count),
        .syncThreshold(sync_th), .acqLead(acq_lead), .acqLag(acq_lag),
        .trkLead(trk_lead), .trkLag(trk_lag), .leadExp(lead_exp),
        .lagExp(lag_exp), .zeroError(zero_err), .clearAccum(clr_acc),
        .lockDetect(lock_det), .state(st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clk edge of the sequencer, written from the behavioural rules.
    task automatic model_step();
        int  mag, lc, hit_run, sat_run, miss_run, acq_run;
        bit  inth, satf, restart;
        mag = $signed(err);
        if (mag < 0) mag = -mag;
        if (mag > 127) mag = 127;
        inth = (mag <= int'(sync_th));
        satf = sat_pos | sat_neg;
        lc   = (lock_count == 16'd0) ? 1 : int'(lock_count);
        m_clr = 1'b0;
        if (rst || !en) begin
            m_mode = M_IDLE; m_hit = 0; m_miss = 0; m_sat = 0; m_acq = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ACQ;
            m_clr  = 1'b1;
        end else if (clk_en) begin
            if (m_mode == M_ACQ) begin
                hit_run = inth ? ((m_hit < 65535) ? m_hit + 1 : m_hit) : 0;
                sat_run = satf ? m_sat + 1 : 0;
                acq_run = m_acq + 1;
                restart = 1'b0;
`ifdef LOOP_GEAR_TIMEOUT_EN
                restart = (acq_run >= ACQ_TIMEOUT);
`endif
                if (sat_run >= SAT_LIMIT) begin
                    m_clr = 1'b1; m_sat = 0; m_hit = 0;
                    m_acq = restart ? 0 : acq_run;
                end else if (hit_run >= lc) begin
                    m_mode = M_VERIFY; m_hit = 0; m_sat = 0; m_acq = 0;
                end else if (restart) begin
                    m_clr = 1'b1; m_hit = 0; m_sat = sat_run; m_acq = 0;
                end else begin
                    m_hit = hit_run; m_sat = sat_run; m_acq = acq_run;
                end
            end else if (m_mode == M_VERIFY) begin
                if (satf || !inth) begin
                    m_mode = M_ACQ; m_hit = 0;
                end else if (m_hit + 1 >= lc) begin
                    m_mode = M_TRACK; m_hit = 0;
                end else begin
                    m_hit = m_hit + 1;
                end
            end else begin
                miss_run = inth ? 0 : m_miss + 1;
                if (satf || miss_run >= MISS_LIMIT) begin
                    m_mode = M_ACQ; m_miss = 0;
                end else begin
                    m_miss = miss_run;
                end
            end
        end
        m_zero = (m_mode == M_IDLE);
        m_lock = (m_mode == M_TRACK);
        m_lead = (m_mode >= M_VERIFY) ? int'(trk_lead) : int'(acq_lead);
        m_lag  = (m_mode >= M_VERIFY) ? int'(trk_lag)  : int'(acq_lag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("state", int'(st), m_mode);
        check("leadExp", int'(lead_exp), m_lead);
        check("lagExp", int'(lag_exp), m_lag);
        check("zeroError", int'(zero_err), int'(m_zero));
        check("clearAccum", int'(clr_acc), int'(m_clr));
        check("lockDetect", int'(lock_det), int'(m_lock));
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        bit         ce;
        logic [7:0] e;
        int         st;
        bit         clr;
        bit         lock;
        bit         zero;
        int         lead;
        int         lag;
    } vec_t;

    vec_t vt[12];

    initial begin
        int pulses;
        int v;

        rst = 1'b1; en = 1'b1; clk_en = 1'b0; err = 8'd5;
        sat_pos = 1'b0; sat_neg = 1'b0;
        lock_count = 16'd4; sync_th = 8'd10;
        acq_lead = 5'd3; acq_lag = 5'd10; trk_lead = 5'd1; trk_lag = 5'd18;

        // reset, release, qualification through VERIFY into TRACK
        vt[0]  = '{1, 1, 0, 8'd5, 0, 0, 0, 1, 3, 10};
        vt[1]  = '{1, 1, 0, 8'd5, 0, 0, 0, 1, 3, 10};
        vt[2]  = '{0, 1, 0, 8'd5, 1, 1, 0, 0, 3, 10};
        vt[3]  = '{0, 1, 0, 8'd5, 1, 0, 0, 0, 3, 10};
        vt[4]  = '{0, 1, 1, 8'd5, 1, 0, 0, 0, 3, 10};
        vt[5]  = '{0, 1, 1, 8'd5, 1, 0, 0, 0, 3, 10};
        vt[6]  = '{0, 1, 1, 8'd5, 1, 0, 0, 0, 3, 10};
        vt[7]  = '{0, 1, 1, 8'd5, 2, 0, 0, 0, 1, 18};
        vt[8]  = '{0, 1, 1, 8'd5, 2, 0, 0, 0, 1, 18};
        vt[9]  = '{0, 1, 1, 8'd5, 2, 0, 0, 0, 1, 18};
        vt[10] = '{0, 1, 1, 8'd5, 2, 0, 0, 0, 1, 18};
        vt[11] = '{0, 1, 1, 8'd5, 3, 0, 1, 0, 1, 18};

        for (int i = 0; i < 12; i++) begin
            rst = vt[i].rst; en = vt[i].en; clk_en = vt[i].ce; err = vt[i].e;
            tick();
            check("tbl_state", int'(st), vt[i].st);
            check("tbl_clearAccum", int'(clr_acc), int'(vt[i].clr));
            check("tbl_lockDetect", int'(lock_det), int'(vt[i].lock));
            check("tbl_zeroError", int'(zero_err), int'(vt[i].zero));
            check("tbl_leadExp", int'(lead_exp), vt[i].lead);
            check("tbl_lagExp", int'(lag_exp), vt[i].lag);
        end

        // TRACK: 15 misses then a hit keeps lock; 16 misses drop it
        err = 8'd50;
        for (int i = 0; i < 15; i++) tick();
        err = 8'd5;
        tick();
        check("miss15_state", int'(st), 3);
        check("miss15_lock", int'(lock_det), 1);
        err = 8'd50;
        for (int i = 0; i < 15; i++) tick();
        check("miss15b_state", int'(st), 3);
        tick();
        check("miss16_state", int'(st), 1);
        check("miss16_lock", int'(lock_det), 0);

        // relock, then a single satNeg sample in TRACK
        err = 8'd5;
        for (int i = 0; i < 8; i++) tick();
        check("relock_state", int'(st), 3);
        sat_neg = 1'b1;
        tick();
        sat_neg = 1'b0;
        check("satneg_state", int'(st), 1);
        check("satneg_lock", int'(lock_det), 0);

        // VERIFY kicked out by -128, then 3-in/1-out never qualifies
        for (int i = 0; i < 4; i++) tick();
        check("verify_state", int'(st), 2);
        err = 8'h80;
        tick();
        check("neg128_state", int'(st), 1);
        check("neg128_lead", int'(lead_exp), 3);
        check("neg128_clr", int'(clr_acc), 0);
        for (int r = 0; r < 5; r++) begin
            err = 8'd5;
            for (int i = 0; i < 3; i++) tick();
            err = 8'd60;
            tick();
            check("pattern_state", int'(st), 1);
        end

        // saturation in ACQ: one pulse per SAT_LIMIT samples
        err = 8'd50; sat_pos = 1'b1; pulses = 0;
        for (int i = 0; i < 2 * SAT_LIMIT; i++) begin
            tick();
            if (clr_acc) pulses++;
            if (i == SAT_LIMIT - 1) check("sat_first_pulse", int'(clr_acc), 1);
        end
        sat_pos = 1'b0;
        check("sat_pulses", pulses, 2);

        // enable dropped in TRACK
        err = 8'd5;
        for (int i = 0; i < 8; i++) tick();
        check("pre_drop_state", int'(st), 3);
        en = 1'b0;
        tick();
        check("drop_state", int'(st), 0);
        check("drop_zero", int'(zero_err), 1);
        check("drop_lock", int'(lock_det), 0);
        en = 1'b1;
        tick();
        check("reenter_clr", int'(clr_acc), 1);

`ifdef LOOP_GEAR_TIMEOUT_EN
        // ACQ dwell timeout with a constantly large error
        err = 8'd100; pulses = 0;
        for (int i = 0; i < 3 * ACQ_TIMEOUT; i++) begin
            tick();
            if (clr_acc) pulses++;
        end
        check("timeout_pulses", pulses, 3);
`endif

        // lockCount of zero qualifies on a single sample
        lock_count = 16'd0; err = 8'd5;
        tick();
        check("lc0_state", int'(st), 2);
        lock_count = 16'd4;

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst    = ($urandom_range(0, 399) == 0);
            en     = ($urandom_range(0, 149) != 0);
            clk_en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) begin
                v = int'($urandom_range(0, 255));
            end else begin
                v = int'($urandom_range(0, 30)) - 15;
            end
            err     = v[7:0];
            sat_pos = ($urandom_range(0, 39) == 0);
            sat_neg = ($urandom_range(0, 39) == 0);
            if (n % 250 == 0) begin
                lock_count = 16'($urandom_range(0, 5));
                sync_th    = 8'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 49) == 0) begin
                acq_lead = 5'($urandom); acq_lag = 5'($urandom);
                trk_lead = 5'($urandom); trk_lag = 5'($urandom);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loop_gear_ctrl.md
Name: loop_gear_ctrl

Overview:
- Acquisition/tracking sequencer for the carrier/symbol loop filter.
- Watches the 8-bit loop error, the saturation flags and the programmed lockCount/syncThreshold, then drives the filter's lead/lag gain exponents: wide "acquisition" gear, narrow "tracking" gear.
- Controls the filter's error-zero and accumulator-clear controls and declares lock.
- Sits between the loop register bank and the loop filter datapath.

Parameters:
- MISS_LIMIT, 16: consecutive out-of-threshold samples in TRACK that force a return to ACQ.
- SAT_LIMIT, 8: consecutive saturated samples in ACQ that force an accumulator clear.
- ACQ_TIMEOUT, 65535: samples without reaching VERIFY before restart (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clkEn  in  1  loop sample strobe; all counting and decisions happen only on clkEn cycles
- enable  in  1  loop run enable
- error  in  8  signed two's-complement loop error
- satPos  in  1  filter positive-limit flag
- satNeg  in  1  filter negative-limit flag
- lockCount  in  16  in-threshold samples required per qualification phase
- syncThreshold  in  8  unsigned error magnitude threshold
- acqLead  in  5  acquisition lead exponent
- acqLag  in  5  acquisition lag exponent
- trkLead  in  5  tracking lead exponent
- trkLag  in  5  tracking lag exponent
- leadExp  out  5  lead exponent to the filter
- lagExp  out  5  lag exponent to the filter
- zeroError  out  1  forces filter error to zero
- clearAccum  out  1  one-cycle pulse clearing the lag accumulator
- lockDetect  out  1  loop locked
- state  out  2  current state (for status register)

Behaviour:
- Clock and reset: clk is the only clock; reset is synchronous and active-high.
- Reset values: state=IDLE, leadExp=acqLead, lagExp=acqLag, zeroError=1, clearAccum=0, lockDetect=0, all counters 0.
- Outputs are registered. Decisions are made on a clkEn cycle and become visible on the next clk edge.
- Error magnitude: |error|, with -128 saturating to 127.
  - inTh = magnitude <= syncThreshold (unsigned compare).
  - sat = satPos | satNeg.
- lockCount of 0 is treated as 1.
- States:
  - IDLE (0): zeroError=1, acquisition gear, lockDetect=0.
    - enable=1 → ACQ on the next clk (clkEn not required). clearAccum pulses on that entry.
  - ACQ (1): zeroError=0, acquisition gear.
    - Each clkEn: inTh → hitCnt+1; otherwise hitCnt=0.
    - hitCnt reaching lockCount → VERIFY, hitCnt cleared.
    - sat counts satCnt; any non-sat sample clears satCnt.
    - satCnt reaching SAT_LIMIT → clearAccum pulse, satCnt=0, hitCnt=0, stay in ACQ.
  - VERIFY (2): tracking gear.
    - Each clkEn: inTh → hitCnt+1.
    - !inTh or sat → ACQ, hitCnt=0, clearAccum not pulsed.
    - hitCnt reaching lockCount → TRACK; lockDetect=1 from the same edge.
  - TRACK (3): tracking gear, lockDetect=1.
    - !inTh → missCnt+1; inTh → missCnt=0.
    - missCnt reaching MISS_LIMIT → ACQ, lockDetect=0.
    - Any sat sample → immediate ACQ, lockDetect=0.
- Priority within one sample: reset > enable=0 > sat > threshold logic.
- enable=0 in any state → IDLE on the next clk, counters cleared.
- Gear switching: exponent outputs change on the same edge as the state change. acq*/trk* inputs are sampled every cycle, so register writes take effect one cycle later.
- Counters saturate and never wrap (hitCnt 16-bit, missCnt and satCnt sized from their parameters).
- clearAccum is never asserted for more than one clk.

Optional Feature:
- Macro: LOOP_GEAR_TIMEOUT_EN.
- Defined: an acqCnt counts clkEn samples while in ACQ.
  - Reaching ACQ_TIMEOUT → clearAccum pulse, acqCnt=0, hitCnt=0, stay in ACQ.
  - acqCnt clears on leaving ACQ.
- Undefined: no acqCnt; ACQ may dwell forever.

Decomposition:
- Shared package/include (beside the address map):
  - State encodings IDLE/ACQ/VERIFY/TRACK = 2'd0..3.
  - Exponent width 5, error width 8, count width 16.
- One sub-module: loop_err_mag. Combinational |error| with -128 saturation plus the threshold compare, producing inTh. It is reused by other lock detectors.

Test Plan:
1. Reset held with enable=1 → state=0, zeroError=1, lockDetect=0. Release reset → state=1 and clearAccum=1 for exactly one clk.
2. lockCount=4, syncThreshold=10, error=5 every clkEn → VERIFY after the 4th sample, TRACK after 8 samples. leadExp/lagExp switch from acq (3/10) to trk (1/18) on entering VERIFY; lockDetect=1 in TRACK.
3. In VERIFY, feed error=-128 once (magnitude 127 > 10) → back to ACQ, acquisition gear, hitCnt restarts; a 3-in/1-out pattern never locks.
4. In TRACK with MISS_LIMIT=16: 15 misses then an in-threshold sample → stays locked. 16 consecutive misses → ACQ, lockDetect=0. A single satNeg sample in TRACK → ACQ on the next edge.
5. In ACQ, satPos high for SAT_LIMIT=8 samples → single clearAccum pulse; satPos continuing → another pulse after 8 more samples.
6. enable dropped mid-TRACK → IDLE next clk, zeroError=1, lockDetect=0. With LOOP_GEAR_TIMEOUT_EN and ACQ_TIMEOUT=20, error=100 constantly → clearAccum every 20 samples.
